div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//  Round-robin scheduler sharing one iterative fixed-point divider among NUM_REQ requesters
//  (heading/velocity/scale units in the navigation datapath). Accepts one request at a time,
//  latches operands, sequences the divider (start pulse, wait for done) and returns the tagged
//  quotient. Divide-by-zero is short-circuited without occupying the divider.
// PARAMETERS
//  NUM_REQ     4   number of requesters, 2..8
//  DATA_WIDTH  16  operand/quotient width (signed two's complement, divider's fixed-point format)
//  ID_WIDTH    2   requester index width, >= clog2(NUM_REQ)
//  TIMEOUT     64  max cycles waiting for div_done (used only with DIV_TIMEOUT_EN)
// PORTS
//  clk         in   1                   clock
//  rst         in   1                   synchronous reset, active-high
//  req         in   NUM_REQ             per-requester request level
//  req_a       in   NUM_REQ*DATA_WIDTH  dividends, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//  req_b       in   NUM_REQ*DATA_WIDTH  divisors, same packing
//  grant       out  NUM_REQ             one-hot, 1-cycle pulse: operands of that requester latched
//  resp_valid  out  1                   1-cycle pulse: result fields valid
//  resp_id     out  ID_WIDTH            requester index of result
//  resp_q      out  DATA_WIDTH          quotient
//  resp_dz     out  1                   divisor was zero (resp_q = 0)
//  resp_tmo    out  1                   divider timed out (resp_q = 0); present only with DIV_TIMEOUT_EN
//  div_start   out  1                   1-cycle pulse starting the divider
//  div_a       out  DATA_WIDTH          latched dividend, stable from ISSUE until next grant
//  div_b       out  DATA_WIDTH          latched divisor, same
//  div_done    in   1                   divider result-valid pulse
//  div_q       in   DATA_WIDTH          divider quotient, sampled when div_done=1
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; zero-divisor path IDLE -> RESP.
//  - IDLE: if req!=0, pick first set bit searching ptr+1, ptr+2, ... mod NUM_REQ; that cycle
//    grant[k]=1, latch req_a/req_b slice k into div_a/div_b, latch id=k, set ptr=k.
//    Latched b==0 -> RESP with resp_dz=1, resp_q=0; else -> ISSUE. req==0 -> stay IDLE.
//  - ISSUE: div_start=1 exactly one cycle -> WAIT.
//  - WAIT: on div_done latch div_q -> RESP. div_done in IDLE/ISSUE/RESP ignored.
//  - RESP: resp_valid=1 one cycle with resp_id/resp_q/resp_dz/resp_tmo -> IDLE.
//    Result fields hold until next RESP; valid only qualified by resp_valid.
//  - Latency: grant at cycle T; div_start at T+1; div_done at T+1+D gives resp_valid at T+2+D.
//    Zero-divisor: resp_valid at T+1. Next grant no earlier than cycle after RESP.
//  - Requester rules: hold req and operands stable until grant; req still high the cycle after
//    grant counts as a new request. No backpressure on response.
//  - Fairness: pointer advances only on grant; continuously requesting requester waits at most
//    NUM_REQ-1 other divisions.
//  - Reset (any state, incl. mid-division): state=IDLE, ptr=NUM_REQ-1 (requester 0 first),
//    grant=0, div_start=0, resp_valid=0, resp_id=0, resp_q=0, resp_dz=0, resp_tmo=0,
//    div_a=div_b=0. In-flight division discarded; a late div_done after reset is ignored.
// CONFIGURATION
//  DIV_TIMEOUT_EN defined: cycle counter cleared on ISSUE, increments in WAIT; reaching TIMEOUT
//   without div_done -> RESP with resp_tmo=1, resp_q=0, resp_dz=0. div_done on the same cycle
//   as expiry wins (normal result). Counter wide enough for TIMEOUT.
//  DIV_TIMEOUT_EN undefined: no counter, no resp_tmo port; WAIT exits only on div_done.
// TESTING
//  - Single: req=0001, a=0x0600, b=0x0200, done D=33 later with q=0x0300 -> grant[0] at T,
//    div_start T+1, resp_valid T+35, id=0, q=0x0300, dz=0.
//  - Round-robin: req=1111 held throughout -> grant order 0,1,2,3,0; resp_id sequence matches.
//  - Zero divisor: req=0100, b=0 -> grant[2] at T, no div_start, resp_valid T+1, id=2, dz=1, q=0.
//  - Reset mid-WAIT: rst one cycle during WAIT, then div_done -> no resp_valid; next req=0010
//    granted normally; all outputs 0 in cycle after rst.
//  - Negative operands: a=0xFA00, b=0x0200, div_q=0xFD00 -> resp_q=0xFD00, div_a/div_b passed
//    unmodified.
//  - DIV_TIMEOUT_EN, TIMEOUT=64: div_done never asserted -> resp_valid with resp_tmo=1, q=0
//    exactly 65 cycles after div_start; then next pending request granted.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one iterative fixed-point divider among NUM_REQ requesters.
// Optional divider watchdog enabled by defining DIV_TIMEOUT_EN (adds the resp_tmo port).
module div_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_q,
  output logic                          resp_dz,
`ifdef DIV_TIMEOUT_EN
  output logic                          resp_tmo,
`endif
  output logic                          div_start,
  output logic [DATA_WIDTH-1:0]         div_a,
  output logic [DATA_WIDTH-1:0]         div_b,
  input  logic                          div_done,
  input  logic [DATA_WIDTH-1:0]         div_q
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state;
  logic [IdxW-1:0]       ptr;
  logic [IdxW-1:0]       pick;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
  int unsigned           idx;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[k] = req_b[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester after the last winner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!pick_found && req[IdxW'(idx)]) begin
        pick_found = 1'b1;
        pick       = IdxW'(idx);
      end
    end
  end

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      ptr        <= IdxW'(NUM_REQ - 1);
      cur_id     <= '0;
      grant      <= '0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_q     <= '0;
      resp_dz    <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      resp_tmo   <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      grant     <= '0;
      div_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pick_found) begin
            grant  <= NUM_REQ'(1) << pick;
            div_a  <= a_arr[pick];
            div_b  <= b_arr[pick];
            cur_id <= ID_WIDTH'(pick);
            ptr    <= pick;
            state  <= (b_arr[pick] == '0) ? StResp : StIssue;
          end
        end
        StIssue: begin
          div_start <= 1'b1;
`ifdef DIV_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= StWait;
        end
        StWait: begin
          if (div_done) begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_q     <= div_q;
            resp_dz    <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            resp_tmo   <= 1'b0;
`endif
            state      <= StResp;
          end
`ifdef DIV_TIMEOUT_EN
          else if (tmo_cnt == CntW'(TIMEOUT)) begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_q     <= '0;
            resp_dz    <= 1'b0;
            resp_tmo   <= 1'b1;
            state      <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        StResp: begin
          // Entered without resp_valid only on the zero-divisor path.
          if (resp_valid) begin
            resp_valid <= 1'b0;
            state      <= StIdle;
          end else begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_q     <= '0;
            resp_dz    <= 1'b1;
`ifdef DIV_TIMEOUT_EN
            resp_tmo   <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural Q8.8 divider model.
// Define DIV_TIMEOUT_EN to exercise the watchdog path.
module tb_div_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] q;
    logic          dz;
    logic          tmo;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_a = '0;
  logic [NR*DW-1:0]  req_b = '0;
  logic [NR-1:0]     grant;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_q;
  logic              resp_dz;
  logic              tmo_sig;
  logic              div_start;
  logic [DW-1:0]     div_a;
  logic [DW-1:0]     div_b;
  logic              div_done = 1'b0;
  logic [DW-1:0]     div_q = '0;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  resp_t sb[$];

  // Divider model controls
  bit          div_mode = 1'b1;  // 0: never answers
  int          div_lat = 4;
  int          inj_req = 0;
  int          inj_seen = 0;
  logic [DW-1:0] inj_q = '0;
  bit          busy = 1'b0;
  int          left = 0;
  logic [DW-1:0] ma, mb;
  logic signed [31:0] mt;

  div_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
    .resp_dz    (resp_dz),
`ifdef DIV_TIMEOUT_EN
    .resp_tmo   (tmo_sig),
`endif
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_q      (div_q)
  );

`ifndef DIV_TIMEOUT_EN
  assign tmo_sig = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: done pulse div_lat cycles after the div_start cycle, Q8.8 signed quotient.
  always @(posedge clk) begin
    #1;
    div_done = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        div_done = 1'b1;
        div_q    = inj_q;
      end else if (busy) begin
        left = left - 1;
        if (left == 0) begin
          mt       = ($signed({{16{ma[15]}}, ma}) <<< 8) / $signed({{16{mb[15]}}, mb});
          div_q    = mt[DW-1:0];
          div_done = 1'b1;
          busy     = 1'b0;
        end
      end
      if (div_start && div_mode) begin
        busy = 1'b1;
        left = div_lat;
        ma   = div_a;
        mb   = div_b;
      end
    end
  end

  function automatic resp_t resp_now();
    resp_t r;
    r.id  = resp_id;
    r.q   = resp_q;
    r.dz  = resp_dz;
    r.tmo = tmo_sig;
    return r;
  endfunction

  // kind 0: grant, 1: div_start, 2: resp_valid; sampled at negedge.
  task automatic wait_ev(input int kind, input int budget, output int at, output bit seen);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((kind == 0 && grant != '0) || (kind == 1 && div_start) || (kind == 2 && resp_valid)) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[k*DW +: DW] = a;
    req_b[k*DW +: DW] = b;
  endtask

  task automatic test_reset();
    int g_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({grant, resp_valid, div_start, resp_id, resp_q, resp_dz, tmo_sig, div_a, div_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b rv=%b st=%b id=%0d q=%h dz=%b tmo=%b a=%h b=%h, expected all 0",
               grant, resp_valid, div_start, resp_id, resp_q, resp_dz, tmo_sig, div_a, div_b);
    end
    rst = 1'b0;
    g_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (grant != '0 || resp_valid || div_start) g_cnt++;
    end
    n_tests++;
    if (g_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d active cycles, expected 0", g_cnt);
    end
  endtask

  task automatic test_single();
    int t, s, r;
    bit seen;
    resp_t e;
    set_op(0, 16'h0600, 16'h0200);
    div_lat = 33;
    req = 4'b0001;
    sb.push_back('{id: 2'd0, q: 16'h0300, dz: 1'b0, tmo: 1'b0});
    wait_ev(0, 50, t, seen);
    req = '0;
    n_tests++;
    if (!seen || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_grant: got %b (seen=%0d), expected 0001", grant, seen);
    end
    wait_ev(1, 10, s, seen);
    n_tests++;
    if (!seen || s != t + 1) begin
      n_fail++;
      $display("FAIL single_start_lat: got cycle %0d, expected %0d", s, t + 1);
    end
    n_tests++;
    if ({div_a, div_b} !== {16'h0600, 16'h0200}) begin
      n_fail++;
      $display("FAIL single_operands: got %h/%h, expected 0600/0200", div_a, div_b);
    end
    wait_ev(2, 100, r, seen);
    n_tests++;
    if (!seen || r != t + 35) begin
      n_fail++;
      $display("FAIL single_resp_lat: got cycle %0d, expected %0d", r, t + 35);
    end
    if (seen) begin
      e = sb.pop_front();
      n_tests++;
      if (resp_now() !== e) begin
        n_fail++;
        $display("FAIL single_resp: got %h, expected %h", resp_now(), e);
      end
    end
  endtask

  task automatic test_round_robin();
    int t, r, prev_r;
    bit seen;
    resp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < NR; k++) set_op(k, DW'((k + 1) << 8), 16'h0100);
    div_lat = 5;
    req = 4'b1111;
    prev_r = -1;
    for (int n = 0; n < 5; n++) begin
      wait_ev(0, 60, t, seen);
      if (n == 4) req = '0;
      n_tests++;
      if (!seen || grant !== NR'(1 << (n % NR))) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, expected %b", n, grant, NR'(1 << (n % NR)));
      end
      n_tests++;
      if (t <= prev_r) begin
        n_fail++;
        $display("FAIL rr_gap[%0d]: got grant cycle %0d, expected > %0d", n, t, prev_r);
      end
      sb.push_back('{id: IW'(n % NR), q: DW'(((n % NR) + 1) << 8), dz: 1'b0, tmo: 1'b0});
      wait_ev(2, 60, r, seen);
      e = sb.pop_front();
      n_tests++;
      if (!seen || resp_now() !== e) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: got %h (seen=%0d), expected %h", n, resp_now(), seen, e);
      end
      prev_r = r;
    end
  endtask

  task automatic test_zero_div();
    int t, r;
    bit seen;
    resp_t e;
    set_op(2, 16'h1234, 16'h0000);
    req = 4'b0100;
    sb.push_back('{id: 2'd2, q: 16'h0000, dz: 1'b1, tmo: 1'b0});
    wait_ev(0, 20, t, seen);
    req = '0;
    n_tests++;
    if (!seen || grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL zero_grant: got %b, expected 0100", grant);
    end
    wait_ev(2, 10, r, seen);
    n_tests++;
    if (!seen || r != t + 1 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_lat: got cycle %0d start=%b, expected %0d start=0", r, div_start, t + 1);
    end
    e = sb.pop_front();
    n_tests++;
    if (resp_now() !== e) begin
      n_fail++;
      $display("FAIL zero_resp: got %h, expected %h", resp_now(), e);
    end
  endtask

  task automatic test_negative();
    int t, s, r;
    bit seen;
    resp_t e;
    set_op(3, 16'hFA00, 16'h0200);
    div_lat = 7;
    req = 4'b1000;
    sb.push_back('{id: 2'd3, q: 16'hFD00, dz: 1'b0, tmo: 1'b0});
    wait_ev(0, 20, t, seen);
    req = '0;
    n_tests++;
    if (!seen || grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL neg_grant: got %b, expected 1000", grant);
    end
    wait_ev(1, 10, s, seen);
    n_tests++;
    if (!seen || {div_a, div_b} !== {16'hFA00, 16'h0200}) begin
      n_fail++;
      $display("FAIL neg_operands: got %h/%h, expected FA00/0200", div_a, div_b);
    end
    wait_ev(2, 30, r, seen);
    e = sb.pop_front();
    n_tests++;
    if (!seen || resp_now() !== e) begin
      n_fail++;
      $display("FAIL neg_resp: got %h, expected %h", resp_now(), e);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t, s, r, rv_cnt;
    bit seen;
    resp_t e;
    set_op(0, 16'h0600, 16'h0200);
    div_mode = 1'b0;
    req = 4'b0001;
    wait_ev(0, 20, t, seen);
    req = '0;
    wait_ev(1, 10, s, seen);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, resp_valid, div_start, resp_id, resp_q, resp_dz, tmo_sig, div_a, div_b} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got grant=%b rv=%b st=%b q=%h a=%h b=%h, expected all 0",
               grant, resp_valid, div_start, resp_q, div_a, div_b);
    end
    rst = 1'b0;
    inj_q = 16'h7777;
    inj_req++;
    rv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    n_tests++;
    if (rv_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_late_done: got %0d resp_valid pulses, expected 0", rv_cnt);
    end
    div_mode = 1'b1;
    div_lat = 4;
    set_op(1, 16'h0900, 16'h0300);
    req = 4'b0010;
    sb.push_back('{id: 2'd1, q: 16'h0300, dz: 1'b0, tmo: 1'b0});
    wait_ev(0, 20, t, seen);
    req = '0;
    n_tests++;
    if (!seen || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_next_grant: got %b, expected 0010", grant);
    end
    wait_ev(2, 30, r, seen);
    e = sb.pop_front();
    n_tests++;
    if (!seen || resp_now() !== e) begin
      n_fail++;
      $display("FAIL rst_next_resp: got %h, expected %h", resp_now(), e);
    end
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic test_timeout();
    int t, s, r;
    bit seen;
    resp_t e;
    set_op(0, 16'h0600, 16'h0200);
    set_op(2, 16'h0C00, 16'h0400);
    div_mode = 1'b0;
    req = 4'b0001;
    wait_ev(0, 20, t, seen);
    req = 4'b0100;
    wait_ev(1, 10, s, seen);
    sb.push_back('{id: 2'd0, q: 16'h0000, dz: 1'b0, tmo: 1'b1});
    wait_ev(2, 100, r, seen);
    n_tests++;
    if (!seen || r != s + 65) begin
      n_fail++;
      $display("FAIL tmo_lat: got cycle %0d, expected %0d", r, s + 65);
    end
    e = sb.pop_front();
    n_tests++;
    if (resp_now() !== e) begin
      n_fail++;
      $display("FAIL tmo_resp: got %h, expected %h", resp_now(), e);
    end
    div_mode = 1'b1;
    div_lat = 3;
    sb.push_back('{id: 2'd2, q: 16'h0300, dz: 1'b0, tmo: 1'b0});
    wait_ev(0, 20, t, seen);
    req = '0;
    n_tests++;
    if (!seen || grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL tmo_next_grant: got %b, expected 0100", grant);
    end
    wait_ev(2, 30, r, seen);
    e = sb.pop_front();
    n_tests++;
    if (!seen || resp_now() !== e) begin
      n_fail++;
      $display("FAIL tmo_next_resp: got %h, expected %h", resp_now(), e);
    end
  endtask
`else
  task automatic test_slow_divider();
    int t, s, r;
    bit seen;
    resp_t e;
    set_op(0, 16'h0600, 16'h0200);
    div_lat = 100;
    req = 4'b0001;
    sb.push_back('{id: 2'd0, q: 16'h0300, dz: 1'b0, tmo: 1'b0});
    wait_ev(0, 20, t, seen);
    req = '0;
    wait_ev(1, 10, s, seen);
    wait_ev(2, 200, r, seen);
    n_tests++;
    if (!seen || r != s + 101) begin
      n_fail++;
      $display("FAIL slow_lat: got cycle %0d, expected %0d", r, s + 101);
    end
    e = sb.pop_front();
    n_tests++;
    if (resp_now() !== e) begin
      n_fail++;
      $display("FAIL slow_resp: got %h, expected %h", resp_now(), e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_div();
    test_negative();
    test_reset_mid_wait();
`ifdef DIV_TIMEOUT_EN
    test_timeout();
`else
    test_slow_divider();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
